// File: rtl/array_ctrl_pkg.sv
// Shared constants and types for the array command controller.
package array_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GOT_HDR,
    ST_GOT_CMD,
    ST_GOT_PHASE,
    ST_APPLY,
    ST_ACK
  } state_t;

  localparam logic [7:0] FRAME_HDR  = 8'hFF;
  localparam logic [7:0] FRAME_TAIL = 8'h3C;

  localparam logic [7:0] CMD_LEFT   = 8'h41; // 'A'
  localparam logic [7:0] CMD_RIGHT  = 8'h44; // 'D'
  localparam logic [7:0] CMD_UP     = 8'h57; // 'W'
  localparam logic [7:0] CMD_DOWN   = 8'h53; // 'S'
  localparam logic [7:0] CMD_CENTER = 8'h43; // 'C'
  localparam logic [7:0] CMD_PHASE  = 8'h50; // 'P'

  localparam logic [7:0] ACK_OK    = 8'h06;
  localparam logic [7:0] ACK_CLAMP = 8'h07;
  localparam logic [7:0] ACK_ERR   = 8'h15;

  localparam logic [2:0] POS_RESET = 3'd2;

  function automatic logic cmd_known(input logic [7:0] c);
    return (c == CMD_LEFT) || (c == CMD_RIGHT) || (c == CMD_UP) ||
           (c == CMD_DOWN) || (c == CMD_CENTER) || (c == CMD_PHASE);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter: start loads LOAD_VAL, expired holds once it hits zero.
module frame_timer #(
  parameter int unsigned LOAD_VAL = 249999,
  parameter int unsigned CNT_W    = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic start_i,
  output logic expired_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  // Count down while running; clear idles the timer, start (re)loads it.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start_i) begin
      cnt_q <= CNT_W'(LOAD_VAL);
      run_q <= 1'b1;
    end else if (run_q && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign expired_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/array_cmd_ctrl.sv
// Host frame parser with period-aligned commit of focus position and phase delay.
module array_cmd_ctrl
  import array_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 250000,
  parameter int unsigned POS_MAX     = 4,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             period_wrap,
  output logic [2:0]       pos_x,
  output logic [2:0]       pos_y,
  output logic [9:0]       delay,
  output logic             cfg_strobe,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0]  PMAX  = 3'(POS_MAX);

  state_t           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d, phase_q, phase_d;
  logic [2:0]       pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [9:0]       pend_delay_q, pend_delay_d;
  logic             clamp_q, clamp_d;
  logic [2:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [9:0]       delay_q, delay_d;
  logic             cfg_strobe_q, cfg_strobe_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_inc, tmr_start, tmr_clr, tmr_exp;

  // One timer serves both the byte-gap timeout and the APPLY forced commit;
  // it is restarted by every accepted byte, including the tail.
  frame_timer #(
    .LOAD_VAL(TIMEOUT_CYC - 1),
    .CNT_W   (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr),
    .start_i  (tmr_start),
    .expired_o(tmr_exp)
  );

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      phase_q      <= '0;
      pend_x_q     <= POS_RESET;
      pend_y_q     <= POS_RESET;
      pend_delay_q <= '0;
      clamp_q      <= 1'b0;
      pos_x_q      <= POS_RESET;
      pos_y_q      <= POS_RESET;
      delay_q      <= '0;
      cfg_strobe_q <= 1'b0;
      tx_data_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      phase_q      <= phase_d;
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      pend_delay_q <= pend_delay_d;
      clamp_q      <= clamp_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      delay_q      <= delay_d;
      cfg_strobe_q <= cfg_strobe_d;
      tx_data_q    <= tx_data_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Frame parsing, pending-value computation, commit and acknowledge.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    phase_d      = phase_q;
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    pend_delay_d = pend_delay_q;
    clamp_d      = clamp_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    delay_d      = delay_q;
    cfg_strobe_d = 1'b0;
    tx_data_d    = tx_data_q;
    err_inc      = 1'b0;
    tmr_start    = 1'b0;
    tmr_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == FRAME_HDR)) begin
          state_d   = ST_GOT_HDR;
          tmr_start = 1'b1;
        end
      end
      ST_GOT_HDR, ST_GOT_CMD: begin
        if (rx_valid) begin
          tmr_start = 1'b1;
          if (state_q == ST_GOT_HDR) begin
            cmd_d   = rx_data;
            state_d = ST_GOT_CMD;
          end else begin
            phase_d = rx_data;
            state_d = ST_GOT_PHASE;
          end
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
          err_inc = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      ST_GOT_PHASE: begin
        if (rx_valid) begin
          if ((rx_data == FRAME_TAIL) && cmd_known(cmd_q)) begin
            pend_x_d     = pos_x_q;
            pend_y_d     = pos_y_q;
            pend_delay_d = {phase_q, 2'b00};
            clamp_d      = 1'b0;
            case (cmd_q)
              CMD_LEFT:   if (pos_x_q == '0) clamp_d = 1'b1; else pend_x_d = pos_x_q - 3'd1;
              CMD_RIGHT:  if (pos_x_q == PMAX) clamp_d = 1'b1; else pend_x_d = pos_x_q + 3'd1;
              CMD_UP:     if (pos_y_q == '0) clamp_d = 1'b1; else pend_y_d = pos_y_q - 3'd1;
              CMD_DOWN:   if (pos_y_q == PMAX) clamp_d = 1'b1; else pend_y_d = pos_y_q + 3'd1;
              CMD_CENTER: begin
                pend_x_d = POS_RESET;
                pend_y_d = POS_RESET;
              end
              default: ;
            endcase
            state_d   = ST_APPLY;
            tmr_start = 1'b1;
          end else begin
            tx_data_d = ACK_ERR;
            err_inc   = 1'b1;
            state_d   = ST_ACK;
            tmr_clr   = 1'b1;
          end
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
          err_inc = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      ST_APPLY: begin
        err_inc = rx_valid;
        if (period_wrap || tmr_exp) begin
          pos_x_d      = pend_x_q;
          pos_y_d      = pend_y_q;
          delay_d      = pend_delay_q;
          cfg_strobe_d = 1'b1;
          tx_data_d    = clamp_q ? ACK_CLAMP : ACK_OK;
          state_d      = ST_ACK;
          tmr_clr      = 1'b1;
        end
      end
      ST_ACK: begin
        err_inc = rx_valid;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_cnt_d = (err_inc && (err_cnt_q != '1)) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign delay      = delay_q;
  assign cfg_strobe = cfg_strobe_q;
  assign tx_data    = tx_data_q;
  assign tx_valid   = (state_q == ST_ACK);
  assign busy       = (state_q != ST_IDLE);
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_array_cmd_ctrl.sv
// Self-checking bench: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_array_cmd_ctrl;

  localparam int unsigned T       = 40;
  localparam int unsigned PMAX    = 4;
  localparam int unsigned EW      = 4;
  localparam int          ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          period_wrap = 1'b0;
  logic          tx_ready = 1'b1;
  logic [2:0]    pos_x, pos_y;
  logic [9:0]    delay;
  logic          cfg_strobe, tx_valid, busy;
  logic [7:0]    tx_data;
  logic [EW-1:0] err_cnt;

  int tests = 0;
  int fails = 0;

  array_cmd_ctrl #(.TIMEOUT_CYC(T), .POS_MAX(PMAX), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .period_wrap(period_wrap), .pos_x(pos_x), .pos_y(pos_y), .delay(delay),
    .cfg_strobe(cfg_strobe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  int         m_px, m_py, m_delay, m_txd, m_err;
  bit         m_strobe;
  logic [7:0] frm[$];
  int         gap, waitc;
  int         mode;           // 0 = collecting bytes, 1 = awaiting period, 2 = acknowledging
  int         n_px, n_py, n_delay;
  bit         n_clamp;

  function automatic void bump_err();
    if (m_err < ERR_MAX) m_err++;
  endfunction

  function automatic void eval_frame();
    int nx, ny;
    bit ok;
    ok = 1; nx = m_px; ny = m_py;
    case (frm[1])
      8'h41: nx = m_px - 1;
      8'h44: nx = m_px + 1;
      8'h57: ny = m_py - 1;
      8'h53: ny = m_py + 1;
      8'h43: begin nx = 2; ny = 2; end
      8'h50: ;
      default: ok = 0;
    endcase
    if (frm[3] != 8'h3C) ok = 0;
    if (!ok) begin
      m_txd = 8'h15; bump_err(); mode = 2;
      return;
    end
    n_clamp = 0;
    if (nx < 0) begin nx = 0; n_clamp = 1; end
    if (nx > int'(PMAX)) begin nx = PMAX; n_clamp = 1; end
    if (ny < 0) begin ny = 0; n_clamp = 1; end
    if (ny > int'(PMAX)) begin ny = PMAX; n_clamp = 1; end
    n_px = nx; n_py = ny; n_delay = int'(frm[2]) * 4;
    mode = 1; waitc = 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_px = 2; m_py = 2; m_delay = 0; m_txd = 0; m_err = 0; m_strobe = 0;
      frm.delete(); gap = 0; waitc = 0; mode = 0;
    end else begin
      m_strobe = 0;
      if (mode == 1) begin
        if (rx_valid) bump_err();
        if (period_wrap || waitc == int'(T) - 1) begin
          m_px = n_px; m_py = n_py; m_delay = n_delay; m_strobe = 1;
          m_txd = n_clamp ? 8'h07 : 8'h06; mode = 2;
        end else waitc++;
      end else if (mode == 2) begin
        if (rx_valid) bump_err();
        if (tx_ready) mode = 0;
      end else if (rx_valid) begin
        if (frm.size() > 0 || rx_data == 8'hFF) begin
          frm.push_back(rx_data); gap = 0;
          if (frm.size() == 4) begin
            eval_frame();
            frm.delete();
          end
        end
      end else if (frm.size() > 0) begin
        if (gap == int'(T) - 1) begin frm.delete(); bump_err(); end
        else gap++;
      end
    end
  end

  // Per-cycle comparison against the model, after outputs have settled.
  always @(posedge clk) begin
    #1;
    chk("pos_x", int'(pos_x), m_px);
    chk("pos_y", int'(pos_y), m_py);
    chk("delay", int'(delay), m_delay);
    chk("cfg_strobe", int'(cfg_strobe), int'(m_strobe));
    chk("tx_valid", int'(tx_valid), int'(mode == 2));
    chk("tx_data", int'(tx_data), m_txd);
    chk("busy", int'(busy), int'(mode != 0 || frm.size() > 0));
    chk("err_cnt", int'(err_cnt), m_err);
  end

  // ---------------- stimulus ----------------
  task automatic send_byte(input logic [7:0] b, input logic wrap = 1'b0);
    @(negedge clk); rx_data = b; rx_valid = 1'b1; period_wrap = wrap;
    @(negedge clk); rx_valid = 1'b0; period_wrap = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] ph, input logic [7:0] tl = 8'h3C);
    send_byte(8'hFF); send_byte(c); send_byte(ph); send_byte(tl);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wrap();
    @(negedge clk); period_wrap = 1'b1;
    @(negedge clk); period_wrap = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    idle(2); rst = 1'b0;
  endtask

  logic [7:0] w_py [3] = '{8'd1, 8'd0, 8'd0};
  logic [7:0] w_ack[3] = '{8'h06, 8'h06, 8'h07};

  initial begin
    idle(3); rst = 1'b0;
    chk("rst_pos_x", int'(pos_x), 2);
    chk("rst_pos_y", int'(pos_y), 2);
    chk("rst_busy", int'(busy), 0);

    // Move right with phase 0x10, wrap a few cycles later.
    send_frame(8'h44, 8'h10);
    idle(3);
    wrap();
    chk("t1_strobe", int'(cfg_strobe), 1);
    chk("t1_pos_x", int'(pos_x), 3);
    chk("t1_pos_y", int'(pos_y), 2);
    chk("t1_delay", int'(delay), 10'h040);
    chk("t1_txv", int'(tx_valid), 1);
    chk("t1_ack", int'(tx_data), 8'h06);
    idle(1);
    chk("t1_strobe_off", int'(cfg_strobe), 0);

    // Three 'W' frames from reset: clamp on the third.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h57, 8'h00);
      wrap();
      chk("t2_pos_y", int'(pos_y), int'(w_py[i]));
      chk("t2_ack", int'(tx_data), int'(w_ack[i]));
    end

    // Bad tail.
    do_reset();
    send_frame(8'h44, 8'h20, 8'h55);
    chk("t3_txv", int'(tx_valid), 1);
    chk("t3_ack", int'(tx_data), 8'h15);
    chk("t3_err", int'(err_cnt), 1);
    idle(4);
    chk("t3_pos_x", int'(pos_x), 2);

    // Byte-gap timeout, then a normal frame; wrap coincides with the tail and is ignored.
    do_reset();
    send_byte(8'hFF); send_byte(8'h41);
    idle(T + 5);
    chk("t4_busy", int'(busy), 0);
    chk("t4_err", int'(err_cnt), 1);
    chk("t4_txv", int'(tx_valid), 0);
    send_byte(8'hFF); send_byte(8'h43); send_byte(8'h07); send_byte(8'h3C, 1'b1);
    chk("t4_no_early", int'(cfg_strobe), 0);
    idle(2);
    wrap();
    chk("t4_strobe", int'(cfg_strobe), 1);
    chk("t4_delay", int'(delay), 28);

    // Forced commit without any wrap; a byte during APPLY is dropped and counted.
    do_reset();
    send_frame(8'h53, 8'h08);
    idle(2);
    send_byte(8'h11);
    idle(T);
    chk("t5_pos_y", int'(pos_y), 3);
    chk("t5_delay", int'(delay), 32);
    chk("t5_err", int'(err_cnt), 1);
    chk("t5_busy", int'(busy), 0);

    // Reset while awaiting commit discards the pending values.
    send_frame(8'h44, 8'h01);
    do_reset();
    wrap();
    chk("t5_discard", int'(pos_x), 2);

    // Ack held under back-pressure, error saturation, then reset in ACK.
    tx_ready = 1'b0;
    send_frame(8'h50, 8'h05);
    wrap();
    for (int i = 0; i < 100; i++) begin
      chk("t6_txv_hold", int'(tx_valid), 1);
      chk("t6_txd_hold", int'(tx_data), 8'h06);
      idle(1);
    end
    for (int i = 0; i < 20; i++) send_byte(8'hA5);
    chk("t6_err_sat", int'(err_cnt), ERR_MAX);
    chk("t6_delay", int'(delay), 20);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; tx_ready = 1'b1;
    chk("t6_rst_x", int'(pos_x), 2);
    chk("t6_rst_y", int'(pos_y), 2);
    chk("t6_rst_delay", int'(delay), 0);
    chk("t6_rst_strobe", int'(cfg_strobe), 0);
    chk("t6_rst_txv", int'(tx_valid), 0);
    chk("t6_rst_txd", int'(tx_data), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_err", int'(err_cnt), 0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/array_cmd_ctrl.md
# array_cmd_ctrl

Command controller between the UART receiver and the 8x8 transducer phase array. It parses 4-byte host frames (header, move command, phase, tail), updates the focus position and global phase delay, and commits new settings to the waveform datapath only on a waveform-period boundary, so no transducer output glitches mid-cycle. It also returns one acknowledge byte per complete frame to the UART transmitter.

## Interface
Parameters:
- TIMEOUT_CYC, 250000: maximum gap between frame bytes, and maximum wait for a period boundary (10 ms at 25 MHz).
- POS_MAX, 4: largest focus coordinate. The 4x4 active window fits an 8x8 array.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- period_wrap  in  1  one-cycle pulse from the datapath when the ROM address counter wraps 1023->0.
- pos_x  out  3  committed focus column, 0..POS_MAX.
- pos_y  out  3  committed focus row, 0..POS_MAX.
- delay  out  10  committed phase delay, equal to phase_byte*4.
- cfg_strobe  out  1  one-cycle pulse coincident with the first cycle of new pos/delay values.
- tx_data  out  8  acknowledge byte.
- tx_valid  out  1  acknowledge valid; held until tx_ready.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid&&tx_ready.
- busy  out  1  high in every state except IDLE (drives the status LED).
- err_cnt  out  ERR_W  saturating count of bad or timed-out frames and dropped bytes.

## Operation
- Frame format: 0xFF, cmd, phase, 0x3C.
- Command codes:
  - 'A' (0x41): x-1.
  - 'D' (0x44): x+1.
  - 'W' (0x57): y-1.
  - 'S' (0x53): y+1.
  - 'C' (0x43): set (2,2).
  - 'P' (0x50): phase only.
- States: IDLE, GOT_HDR, GOT_CMD, GOT_PHASE, APPLY, ACK.
- IDLE: a byte of 0xFF -> GOT_HDR. Any other byte is ignored and not counted.
- GOT_HDR: the next byte is latched as cmd -> GOT_CMD.
- GOT_CMD: the next byte is latched as phase -> GOT_PHASE. Any value is accepted, including 0xFF.
- GOT_PHASE, on the next byte:
  - Tail is 0x3C and cmd is valid: compute pending values -> APPLY.
  - Tail is wrong or cmd is unknown: ack = 0x15, err_cnt+1 -> ACK. No commit.
- Position arithmetic: unsigned with clamping.
  - A decrement at 0 stays at 0.
  - An increment at POS_MAX stays at POS_MAX.
  - Any clamp sets the clamped flag. Phase still applies.
- Pending delay = {phase, 2'b00}.
- APPLY: commit on a period_wrap pulse, or when the wait counter reaches TIMEOUT_CYC-1 (forced commit). Then -> ACK.
  - ack = 0x06 normally, 0x07 if clamped.
- ACK: tx_valid=1 with a stable tx_data until tx_ready. On acceptance -> IDLE.
- In GOT_HDR, GOT_CMD and GOT_PHASE, a byte-gap counter restarts on every byte. Reaching TIMEOUT_CYC-1 -> IDLE, err_cnt+1, no ack.
- Any rx_valid during APPLY or ACK: the byte is dropped and err_cnt+1.
- err_cnt saturates at all-ones.

## Timing
- Reset values:
  - pos_x = 2, pos_y = 2, delay = 0.
  - cfg_strobe = 0, tx_valid = 0, tx_data = 0, busy = 0, err_cnt = 0.
  - State = IDLE.
- Reset mid-frame discards the frame and any pending commit; no ack is sent.
- One state transition per accepted byte. The tail byte arriving in cycle t gives state APPLY at t+1.
- A period_wrap in cycle t itself is not used. The first eligible pulse is in a cycle >= t+1.
- period_wrap in cycle w: outputs change at the edge ending w, with cfg_strobe high in cycle w+1 only. tx_valid rises in cycle w+1.
- The forced commit has the same timing as a wrap, relative to the timeout cycle.
- tx_valid && tx_ready in cycle k: tx_valid = 0 and state = IDLE at k+1. A byte arriving at k+1 is parsed.
- rx_valid and timeout expiry in the same cycle: the byte wins and the counter restarts.

## Structure
- Shared package array_ctrl_pkg holds:
  - the state enum;
  - FRAME_HDR = 0xFF and FRAME_TAIL = 0x3C;
  - the command codes;
  - ACK_OK = 0x06, ACK_CLAMP = 0x07, ACK_ERR = 0x15;
  - the reset position constant 2.
- One sub-module, frame_timer: a loadable down-counter with clear/start inputs and an expired output. It is shared by the byte-gap timeout and the APPLY forced commit.

## Test plan
- Frame FF 44 10 3C, then period_wrap 5 cycles later -> pos_x = 3, pos_y = 2, delay = 0x040 and cfg_strobe for 1 cycle, both in the cycle after the wrap; ack 0x06.
- From reset, 'W' three times -> pos_y = 1, 0, 0; acks 0x06, 0x06, 0x07.
- Frame FF 44 20 55 (bad tail) -> no cfg_strobe, positions unchanged, ack 0x15, err_cnt = 1.
- FF 41, then silence for TIMEOUT_CYC cycles -> busy drops, err_cnt = 1, no tx_valid. A following good frame is processed normally.
- Good frame with no period_wrap -> forced commit after TIMEOUT_CYC cycles. A byte sent during APPLY increments err_cnt.
- tx_ready held low for 100 cycles -> tx_valid and tx_data stay stable; rst asserted in ACK -> all outputs return to reset values on the next cycle.
